pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per scanned word (legal range 3..15).
REQ-002 SHALL have derived parameter CNT_W, default $clog2(WORD_W+1), meaning the match-count width.
REQ-003 SHALL have port clk_i, input, 1 bit: clock, rising-edge active.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid_i and req1_valid_i, input, 1 bit each: requester word available.
REQ-006 SHALL have ports req0_data_i and req1_data_i, input, WORD_W bits each: word to scan, MSB first.
REQ-007 SHALL have ports req0_ready_o and req1_ready_o, output, 1 bit each: word accepted this cycle.
REQ-008 SHALL have port res_valid_o, output, 1 bit: result available.
REQ-009 SHALL have port res_ready_i, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port res_id_o, output, 1 bit: requester that owns the result.
REQ-011 SHALL have port res_count_o, output, CNT_W bits: number of "101" matches in the word.
REQ-012 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE SHALL grant round-robin: with one valid requester, grant it; with both valid, grant the one not granted last.
REQ-015 reqN_ready_o SHALL be high only in IDLE while requester N is granted (combinational from both valids); both readys SHALL be low in SHIFT and DONE.
REQ-016 On handshake (valid & ready), SHALL load the data into a shift register, zero the bit counter and match counter, clear the detector, latch the requester id, update the last-grant register, and enter SHIFT.
REQ-017 SHIFT SHALL last exactly WORD_W cycles, presenting one bit per cycle to the detector, MSB first, then enter DONE.
REQ-018 The detector SHALL find overlapping "101" matches, e.g. 10101 gives 2 matches.
REQ-019 The detector SHALL issue a combinational hit when its state is S10 and the bit is 1; each hit SHALL increment the match counter in the same cycle.
REQ-020 Detector history SHALL NOT carry across words: no match may span two words.
REQ-021 The match counter SHALL NOT wrap: for WORD_W=8 the maximum count is 3.
REQ-022 DONE SHALL assert res_valid_o with res_id_o and res_count_o registered and held stable until res_ready_i is high.
REQ-023 DONE with res_ready_i high SHALL return to IDLE on the next cycle; back-to-back accepts SHALL therefore be spaced WORD_W+2 cycles apart.
REQ-024 Latency SHALL be fixed: handshake at cycle T gives res_valid_o high from cycle T+WORD_W+1.
REQ-025 Requester valid changes outside IDLE SHALL have no effect.

Reset
REQ-026 Asserting reset_i SHALL immediately force the following, including mid-SHIFT or mid-DONE: FSM=IDLE, res_valid_o=0, res_id_o=0, res_count_o=0, busy_o=0, detector=IDLE, counters=0.
REQ-027 A partially scanned word SHALL be discarded on reset, with no result produced.
REQ-028 The last-grant register SHALL reset to 1, so req0 wins the first contention.

Structure
REQ-029 A shared package SHALL hold the controller FSM state typedef, the detector state encodings (IDLE, S1, S10, S101), and the pattern constant "101".
REQ-030 SHALL instantiate one sub-module, seq_detector_101, with ports clk_i, reset_i, clear_i, en_i, bit_i, hit_o; its state SHALL advance only when en_i is high and SHALL return to IDLE on clear_i.
REQ-031 Target size is 120-400 lines of RTL in total.

Verification
REQ-032 Reset, then req0 sends 8'b1010_1010, accepted at T -> res_valid_o high at T+9, res_id_o=0, res_count_o=3.
REQ-033 req1 sends 8'b1011_0101 -> res_id_o=1, res_count_o=3 (overlap counted); then 8'b1110_0100 -> res_count_o=0.
REQ-034 Both valid in the same cycle after reset -> req0 accepted first, req1 accepted on the next IDLE, results delivered in order id 0 then id 1.
REQ-035 res_ready_i held low 5 cycles in DONE -> res_valid_o, res_id_o and res_count_o stable; both readys low; busy_o=1.
REQ-036 Word 8'b0000_0010 followed by word 8'b1000_0000 -> both counts 0, no cross-word match.
REQ-037 reset_i pulsed low at the 4th SHIFT cycle -> all outputs at reset values immediately; no result appears; the next word 8'b0000_0101 gives count 1.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller.
// Holds the controller FSM state type, the "101" detector state encodings
// and the pattern constant itself.
package pattern_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_S1   = 2'd1,
        DET_S10  = 2'd2,
        DET_S101 = 2'd3
    } det_state_e;

    localparam logic [2:0] PATTERN_101 = 3'b101;

endpackage

// File: rtl/pattern_scan_ctrl_seq_detector.sv
// seq_detector_101: serial detector for overlapping "101" patterns.
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - asynchronous active-low reset, returns the detector to IDLE
//   clear_i - synchronous clear to IDLE (drops history between words)
//   en_i    - a new bit is presented this cycle; state advances only then
//   bit_i   - serial data bit
//   hit_o   - combinational: state is S10 and the current bit completes "101"
module seq_detector_101
    import pattern_scan_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic bit_i,
    output logic hit_o
);

    det_state_e r_state;
    det_state_e w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            DET_IDLE: w_next = (bit_i == PATTERN_101[2]) ? DET_S1 : DET_IDLE;
            // A repeated leading 1 keeps us in S1 rather than restarting.
            DET_S1:   w_next = (bit_i == PATTERN_101[1]) ? DET_S10 : DET_S1;
            DET_S10:  w_next = (bit_i == PATTERN_101[0]) ? DET_S101 : DET_IDLE;
            // The trailing 1 of a match is the leading 1 of the next one.
            DET_S101: w_next = (bit_i == PATTERN_101[1]) ? DET_S10 : DET_S1;
            default:  w_next = DET_IDLE;
        endcase
    end

    assign hit_o = en_i && (r_state == DET_S10) && (bit_i == PATTERN_101[0]);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= DET_IDLE;
        end else if (clear_i) begin
            r_state <= DET_IDLE;
        end else if (en_i) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: two-requester round-robin front end that serially scans
// each accepted word MSB first and reports how many overlapping "101"
// patterns it contains.
// Ports:
//   clk_i, reset_i                 - clock (rising) and async active-low reset
//   req{0,1}_valid_i / _data_i     - requester word offers
//   req{0,1}_ready_o               - word accepted this cycle (IDLE only)
//   res_valid_o / res_ready_i      - result handshake, result held until taken
//   res_id_o, res_count_o          - owning requester and match count
//   busy_o                         - controller not in IDLE
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_valid_i,
    input  logic [WORD_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [WORD_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              res_id_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              busy_o
);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_id;
    logic              r_last;     // requester granted most recently
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_hs;
    logic              w_en;
    logic              w_hit;

    // Match counter holds at its ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        w_next       = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On contention the requester not granted last wins.
                w_gnt0 = req0_valid_i && (!req1_valid_i || r_last);
                w_gnt1 = req1_valid_i && (!req0_valid_i || !r_last);
                if (w_gnt0 || w_gnt1) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_bit_cnt == CNT_W'(WORD_W - 1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign w_hs         = w_gnt0 || w_gnt1;
    assign w_en         = (r_state == ST_SHIFT);
    assign res_valid_o  = (r_state == ST_DONE);
    assign busy_o       = (r_state != ST_IDLE);
    assign res_id_o     = r_id;
    assign res_count_o  = r_count;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
        end else if (w_hs) begin
            r_shift   <= w_gnt1 ? req1_data_i : req0_data_i;
            r_bit_cnt <= '0;
            r_count   <= '0;
            r_id      <= w_gnt1;
            r_last    <= w_gnt1;
        end else if (w_en) begin
            r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_hit) r_count <= sat_inc(r_count);
        end
    end

    // Cleared on every accept so no match can span two words.
    seq_detector_101 u_det (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_hs),
        .en_i    (w_en),
        .bit_i   (r_shift[WORD_W-1]),
        .hit_o   (w_hit)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic [W-1:0]  req0_data_i = '0, req1_data_i = '0;
    logic          req0_ready_o, req1_ready_o;
    logic          res_valid_o, res_id_o, busy_o;
    logic          res_ready_i = 1'b0;
    logic [CW-1:0] res_count_o;

    pattern_scan_ctrl #(.WORD_W(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_id_o     (res_id_o),
        .res_count_o  (res_count_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit id;
        int cnt;
        int t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   last_gnt = 1'b1;
    bit   hold_low = 1'b0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count every 3-bit window equal to 101 within the word.
    function automatic int count101(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i <= W - 3; i++)
            if (w[i+2 -: 3] == 3'b101) n++;
        return n;
    endfunction

    // Consumer: mostly ready, or forced low for the hold test.
    always @(posedge clk) begin
        #1;
        res_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard. One word is in flight at most, so the controller
    // is idle exactly when nothing is outstanding.
    always @(negedge clk) begin
        bit   idle, e0, e1;
        exp_t e;
        if (reset_i) begin
            idle = (sb.size() == 0);
            e0 = idle && req0_valid_i && (!req1_valid_i || last_gnt);
            e1 = idle && req1_valid_i && (!req0_valid_i || !last_gnt);
            chk("ready0", req0_ready_o, e0);
            chk("ready1", req1_ready_o, e1);
            chk("busy", busy_o, !idle);
            if (res_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", cyc - sb[0].t, W + 1);
                    end
                    chk("res_id", res_id_o, sb[0].id);
                    chk("res_count", res_count_o, sb[0].cnt);
                    if (res_ready_i) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (e0 || e1) begin
                e.id  = e1;
                e.cnt = count101(e1 ? req1_data_i : req0_data_i);
                e.t   = cyc;
                sb.push_back(e);
                last_gnt = e1;
            end
        end
    end

    task automatic send(input bit v0, input bit v1, input logic [W-1:0] d0, input logic [W-1:0] d1);
        bit p0, p1, h0, h1;
        int n;
        p0 = v0; p1 = v1; n = 0;
        @(posedge clk); #1;
        req0_valid_i = v0; req0_data_i = d0;
        req1_valid_i = v1; req1_data_i = d1;
        while ((p0 || p1) && n < 300) begin
            @(negedge clk);
            h0 = req0_valid_i && req0_ready_o;
            h1 = req1_valid_i && req1_ready_o;
            @(posedge clk); #1;
            if (h0) begin p0 = 1'b0; req0_valid_i = 1'b0; req0_data_i = W'($urandom); end
            if (h1) begin p1 = 1'b0; req1_valid_i = 1'b0; req1_data_i = W'($urandom); end
            n++;
        end
        if (p0 || p1) begin
            chk("send_timeout", 1, 0);
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_outstanding", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, res_valid_o, 0);
        chk({tag, "_res_id"}, res_id_o, 0);
        chk({tag, "_res_count"}, res_count_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ready0"}, req0_ready_o, 0);
        chk({tag, "_ready1"}, req1_ready_o, 0);
    endtask

    // Asynchronous reset pulse a few ns after a rising edge.
    task automatic reset_pulse(input string tag);
        reset_i = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        sb.delete();
        seen = 1'b0;
        last_gnt = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk); @(posedge clk); #2;
        reset_i = 1'b1;
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("por");
        @(posedge clk); #2;
        reset_i = 1'b1;

        send(1, 0, 8'b1010_1010, 8'h00);
        send(0, 1, 8'h00, 8'b1011_0101);
        send(0, 1, 8'h00, 8'b1110_0100);
        drain();

        @(posedge clk); #3;
        reset_pulse("rst_contention");
        send(1, 1, 8'b0101_1010, 8'b1010_0101);
        drain();

        hold_low = 1'b1;
        send(1, 0, 8'b0010_1101, 8'h00);
        n = 0;
        while (!res_valid_o && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("hold_result_seen", res_valid_o, 1);
        repeat (5) @(posedge clk);
        hold_low = 1'b0;
        drain();

        send(1, 0, 8'b0000_0010, 8'h00);
        send(1, 0, 8'b1000_0000, 8'h00);
        drain();

        send(1, 0, 8'b1010_1101, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        reset_pulse("rst_midshift");
        repeat (15) @(posedge clk);
        send(1, 0, 8'b0000_0101, 8'h00);
        drain();

        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            send(sel[0], sel[1], W'($urandom), W'($urandom));
        end
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
